// File: rtl/ascon_block_feeder.sv
// Byte-stream to 64-bit big-endian block packer with a 2-entry block FIFO feeding the ASCON core.
// Optional byte counter output enabled by defining ASCON_FEEDER_BYTECNT_EN.
module ascon_block_feeder #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_nodata,
    output logic        in_ready,
    input  logic        read,
    output logic [63:0] blockin,
    output logic [3:0]  datalen,
    output logic        blk_valid,
    output logic        blk_last,
    output logic        underflow
`ifdef ASCON_FEEDER_BYTECNT_EN
    ,
    output logic [15:0] byte_count
`endif
);

    // state      | meaning
    // ST_ACC     | accumulating bytes into the pack register
    // ST_EMPTY   | full final block sent; owe the trailing empty block
    typedef enum logic {ST_ACC = 1'b0, ST_EMPTY = 1'b1} state_t;

    localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] pack_q, pack_d;
    logic [63:0] fifo_data_q [2];
    logic [63:0] fifo_data_d [2];
    logic [3:0]  fifo_len_q [2];
    logic [3:0]  fifo_len_d [2];
    logic        fifo_last_q [2];
    logic        fifo_last_d [2];
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic        underflow_q, underflow_d;

    logic        fifo_full;
    logic        accept;
    logic        pend_push;
    logic        pop;
    logic        push;
    logic [63:0] push_data;
    logic [3:0]  push_len;
    logic        push_last;
    logic [2:0]  lane;
    logic [63:0] pack_new;
    logic [3:0]  len_new;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_ACC;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept && !in_nodata && in_last && cnt_q == 3'd7) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_EMPTY: begin
                    if (!fifo_full) begin
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_comb begin
        fifo_full = (fifo_cnt_q == DEPTH_C);
        in_ready  = ready_q && !fifo_full && (state_q == ST_ACC) && !start;
        accept    = in_valid && in_ready;
        pend_push = (state_q == ST_EMPTY) && !fifo_full && !start;
        pop       = read && (fifo_cnt_q != 2'd0) && !start;
    end

    // Packer: the first byte of a block lands in the most significant lane.
    always_comb begin
        lane      = 3'd7 - cnt_q;
        pack_new  = pack_q;
        pack_new[{lane, 3'b000} +: 8] = in_data;
        len_new   = {1'b0, cnt_q} + 4'd1;
        cnt_d     = cnt_q;
        pack_d    = pack_q;
        push      = 1'b0;
        push_data = '0;
        push_len  = '0;
        push_last = 1'b0;
        if (start) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (pend_push) begin
            push      = 1'b1;
            push_last = 1'b1;
        end else if (accept) begin
            if (in_nodata) begin
                push      = 1'b1;
                push_data = pack_q;
                push_len  = {1'b0, cnt_q};
                push_last = 1'b1;
                cnt_d     = '0;
                pack_d    = '0;
            end else if (cnt_q == 3'd7 || in_last) begin
                push      = 1'b1;
                push_data = pack_new;
                push_len  = len_new;
                push_last = (cnt_q != 3'd7);
                cnt_d     = '0;
                pack_d    = '0;
            end else begin
                cnt_d  = cnt_q + 3'd1;
                pack_d = pack_new;
            end
        end
    end

    // Block FIFO: entry 0 is the head; vacated entries are zeroed so an empty FIFO shows zeros.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_len_d  = fifo_len_q;
        fifo_last_d = fifo_last_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (start) begin
            fifo_data_d = '{default: '0};
            fifo_len_d  = '{default: '0};
            fifo_last_d = '{default: 1'b0};
            fifo_cnt_d  = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt_q == 2'd0) begin
                        fifo_data_d[0] = push_data;
                        fifo_len_d[0]  = push_len;
                        fifo_last_d[0] = push_last;
                    end else begin
                        fifo_data_d[1] = push_data;
                        fifo_len_d[1]  = push_len;
                        fifo_last_d[1] = push_last;
                    end
                    fifo_cnt_d = fifo_cnt_q + 2'd1;
                end
                2'b01: begin
                    fifo_data_d[0] = fifo_data_q[1];
                    fifo_len_d[0]  = fifo_len_q[1];
                    fifo_last_d[0] = fifo_last_q[1];
                    fifo_data_d[1] = '0;
                    fifo_len_d[1]  = '0;
                    fifo_last_d[1] = 1'b0;
                    fifo_cnt_d     = fifo_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_q == 2'd1) begin
                        fifo_data_d[0] = push_data;
                        fifo_len_d[0]  = push_len;
                        fifo_last_d[0] = push_last;
                    end else begin
                        fifo_data_d[0] = fifo_data_q[1];
                        fifo_len_d[0]  = fifo_len_q[1];
                        fifo_last_d[0] = fifo_last_q[1];
                        fifo_data_d[1] = push_data;
                        fifo_len_d[1]  = push_len;
                        fifo_last_d[1] = push_last;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ready_d     = 1'b1;
        underflow_d = underflow_q;
        if (start) begin
            underflow_d = 1'b0;
        end else if (read && fifo_cnt_q == 2'd0) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ready_q     <= 1'b0;
            cnt_q       <= '0;
            pack_q      <= '0;
            fifo_data_q <= '{default: '0};
            fifo_len_q  <= '{default: '0};
            fifo_last_q <= '{default: 1'b0};
            fifo_cnt_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            fifo_data_q <= fifo_data_d;
            fifo_len_q  <= fifo_len_d;
            fifo_last_q <= fifo_last_d;
            fifo_cnt_q  <= fifo_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign blockin   = fifo_data_q[0];
    assign datalen   = fifo_len_q[0];
    assign blk_last  = fifo_last_q[0];
    assign blk_valid = (fifo_cnt_q != 2'd0);
    assign underflow = underflow_q;

`ifdef ASCON_FEEDER_BYTECNT_EN
    logic [15:0] byte_count_q, byte_count_d;

    always_comb begin
        byte_count_d = byte_count_q;
        if (start) begin
            byte_count_d = '0;
        end else if (accept && !in_nodata && byte_count_q != 16'hFFFF) begin
            byte_count_d = byte_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            byte_count_q <= '0;
        end else begin
            byte_count_q <= byte_count_d;
        end
    end

    assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_ascon_block_feeder.sv
// Scoreboard bench for ascon_block_feeder: expected blocks queued as bytes are accepted, checked on pop.
module tb_ascon_block_feeder;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  len;
        logic        last;
    } blk_t;

    logic        clk;
    logic        nRST;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_nodata;
    logic        in_ready;
    logic        read;
    logic [63:0] blockin;
    logic [3:0]  datalen;
    logic        blk_valid;
    logic        blk_last;
    logic        underflow;
`ifdef ASCON_FEEDER_BYTECNT_EN
    logic [15:0] byte_count;
`endif

    int          checks = 0;
    int          errors = 0;
    blk_t        exp_q[$];
    int          mcnt = 0;
    logic [63:0] mpack = '0;

    ascon_block_feeder #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_nodata (in_nodata),
        .in_ready  (in_ready),
        .read      (read),
        .blockin   (blockin),
        .datalen   (datalen),
        .blk_valid (blk_valid),
        .blk_last  (blk_last),
        .underflow (underflow)
`ifdef ASCON_FEEDER_BYTECNT_EN
        ,
        .byte_count(byte_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        mcnt  = 0;
        mpack = '0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [7:0] d, input logic last, input logic nodata);
        if (nodata) begin
            exp_q.push_back(blk_t'{mpack, 4'(mcnt), 1'b1});
            mcnt  = 0;
            mpack = '0;
        end else begin
            mpack[63-8*mcnt -: 8] = d;
            mcnt++;
            if (mcnt == 8) begin
                exp_q.push_back(blk_t'{mpack, 4'd8, 1'b0});
                if (last) exp_q.push_back(blk_t'{64'd0, 4'd0, 1'b1});
                mcnt  = 0;
                mpack = '0;
            end else if (last) begin
                exp_q.push_back(blk_t'{mpack, 4'(mcnt), 1'b1});
                mcnt  = 0;
                mpack = '0;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [7:0] d, input logic last, input logic nodata);
        int waitc = 0;
        in_data   = d;
        in_valid  = 1'b1;
        in_last   = last;
        in_nodata = nodata;
        @(negedge clk);
        while (in_ready !== 1'b1 && waitc < 50) begin
            waitc++;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1 (byte %h)", in_ready, d);
        end else begin
            model_accept(d, last, nodata);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_nodata = 1'b0;
    endtask

    task automatic pop_check(input string name);
        int waitc = 0;
        blk_t e;
        @(negedge clk);
        while (blk_valid !== 1'b1 && waitc < 20) begin
            waitc++;
            @(negedge clk);
        end
        checks++;
        if (blk_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_pop: blk_valid=%b required 1, expected entries=%0d", name, blk_valid, exp_q.size());
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if (blockin !== e.data || datalen !== e.len || blk_last !== e.last) begin
                errors++;
                $display("FAIL %s_block: got %h/len %0d/last %b required %h/len %0d/last %b",
                         name, blockin, datalen, blk_last, e.data, e.len, e.last);
            end
        end
        read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            pop_check(name);
            guard++;
        end
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_empty_after: blk_valid=%b required 0", name, blk_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; start = 1'b0; read = 1'b0;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_nodata = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || blockin !== 64'd0 || datalen !== 4'd0 || blk_valid !== 1'b0 ||
            blk_last !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b blk=%h len=%0d v=%b l=%b uf=%b required all 0",
                     in_ready, blockin, datalen, blk_valid, blk_last, underflow);
        end
`ifdef ASCON_FEEDER_BYTECNT_EN
        checks++;
        if (byte_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_byte_count: got %0d required 0", byte_count);
        end
`endif
        @(negedge clk);
        nRST = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        end
        model_clear();
    endtask

    task automatic test_partial();
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        checks++;
        if (blk_valid !== 1'b1 || blockin !== 64'h1122330000000000 || datalen !== 4'd3 || blk_last !== 1'b1) begin
            errors++;
            $display("FAIL partial_latency: v=%b blk=%h len=%0d last=%b required 1/1122330000000000/3/1",
                     blk_valid, blockin, datalen, blk_last);
        end
        drain("partial");
    endtask

    task automatic test_full_final();
        for (int i = 1; i <= 8; i++) send(8'(i), (i == 8), 1'b0);
        checks++;
        if (in_ready !== 1'b0 || blockin !== 64'h0102030405060708 || datalen !== 4'd8 || blk_last !== 1'b0) begin
            errors++;
            $display("FAIL full_final: rdy=%b blk=%h len=%0d last=%b required 0/0102030405060708/8/0",
                     in_ready, blockin, datalen, blk_last);
        end
        drain("full_final");
    endtask

    task automatic test_nodata();
        send(8'h00, 1'b0, 1'b1);
        checks++;
        if (blk_valid !== 1'b1 || datalen !== 4'd0 || blk_last !== 1'b1 || blockin !== 64'd0) begin
            errors++;
            $display("FAIL nodata_empty: v=%b len=%0d last=%b blk=%h required 1/0/1/0",
                     blk_valid, datalen, blk_last, blockin);
        end
        drain("nodata_empty");
        for (int i = 0; i < 10; i++) send(8'hA0 + 8'(i), 1'b0, 1'b0);
        send(8'h00, 1'b1, 1'b1);
        drain("nodata_ten");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0, 1'b0);
        in_data  = 8'h99;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_backpressure: in_ready=%b blk_valid=%b required 0/1", in_ready, blk_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pop_check("b2b_first");
        for (int i = 0; i < 7; i++) send(8'h20 + 8'(i), 1'b0, 1'b0);
        in_data  = 8'h27;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || exp_q.size() == 0 || blockin !== exp_q[0].data || datalen !== exp_q[0].len) begin
            errors++;
            $display("FAIL b2b_simul_head: rdy=%b blk=%h len=%0d required 1/%h/8",
                     in_ready, blockin, datalen, (exp_q.size() != 0) ? exp_q[0].data : 64'd0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        model_accept(8'h27, 1'b0, 1'b0);
        read = 1'b1;
        @(posedge clk);
        #1;
        read     = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (blk_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_simul_count: blk_valid=%b in_ready=%b required 1/1", blk_valid, in_ready);
        end
        drain("b2b");
    endtask

    task automatic test_underflow_start();
        read = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_set: got %b required 1", underflow);
        end
        for (int i = 0; i < 9; i++) send(8'h30 + 8'(i), 1'b0, 1'b0);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky: got %b required 1", underflow);
        end
        start    = 1'b1;
        in_data  = 8'hEE;
        in_valid = 1'b1;
        read     = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_ready: in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        read     = 1'b0;
        model_clear();
        checks++;
        if (blk_valid !== 1'b0 || underflow !== 1'b0 || blockin !== 64'd0 || datalen !== 4'd0) begin
            errors++;
            $display("FAIL start_clear: v=%b uf=%b blk=%h len=%0d required 0/0/0/0",
                     blk_valid, underflow, blockin, datalen);
        end
        send(8'h55, 1'b1, 1'b0);
        checks++;
        if (blockin !== 64'h5500000000000000 || datalen !== 4'd1 || blk_last !== 1'b1) begin
            errors++;
            $display("FAIL start_partial_flushed: blk=%h len=%0d last=%b required 5500000000000000/1/1",
                     blockin, datalen, blk_last);
        end
        drain("after_start");
    endtask

`ifdef ASCON_FEEDER_BYTECNT_EN
    task automatic test_byte_count();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_clear();
        checks++;
        if (byte_count !== 16'd0) begin
            errors++;
            $display("FAIL byte_count_start: got %0d required 0", byte_count);
        end
        for (int i = 0; i < 13; i++) send(8'h60 + 8'(i), 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b1);
        checks++;
        if (byte_count !== 16'd13) begin
            errors++;
            $display("FAIL byte_count_13: got %0d required 13", byte_count);
        end
        drain("byte_count");
    endtask
`endif

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) send(8'hC0 + 8'(i), 1'b0, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || blockin !== 64'd0 || datalen !== 4'd0 || blk_valid !== 1'b0 ||
            blk_last !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rdy=%b blk=%h len=%0d v=%b l=%b uf=%b required all 0",
                     in_ready, blockin, datalen, blk_valid, blk_last, underflow);
        end
`ifdef ASCON_FEEDER_BYTECNT_EN
        checks++;
        if (byte_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_byte_count: got %0d required 0", byte_count);
        end
`endif
        @(negedge clk);
        nRST = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        send(8'h77, 1'b1, 1'b0);
        checks++;
        if (blockin !== 64'h7700000000000000 || datalen !== 4'd1 || blk_last !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_flushed: blk=%h len=%0d last=%b required 7700000000000000/1/1",
                     blockin, datalen, blk_last);
        end
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_partial();
        test_full_final();
        test_nodata();
        test_back_to_back();
        test_underflow_start();
`ifdef ASCON_FEEDER_BYTECNT_EN
        test_byte_count();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
